// File: rtl/bip2_boot_loader_if.sv
// Host byte link and instruction-memory write port of the BIP2 boot loader.
// The master modport is the loader side and the slave modport is the host/memory side.
interface bip2_boot_loader_if #(
    parameter int OPERAND_ADDRESS_WIDTH  = 11,
    parameter int INSTRUCTION_DATA_WIDTH = 16
);
    logic [7:0]                        load_data_in;
    logic                              load_valid_in;
    logic                              load_ready_out;
    logic [OPERAND_ADDRESS_WIDTH-1:0]  imem_address_out;
    logic [INSTRUCTION_DATA_WIDTH-1:0] imem_data_out;
    logic                              imem_wr_out;

    modport master (
        input  load_data_in,
        input  load_valid_in,
        output load_ready_out,
        output imem_address_out,
        output imem_data_out,
        output imem_wr_out
    );

    modport slave (
        output load_data_in,
        output load_valid_in,
        input  load_ready_out,
        input  imem_address_out,
        input  imem_data_out,
        input  imem_wr_out
    );
endinterface

// File: rtl/bip2_boot_loader.sv
// BIP2 boot sequencer: loads a little-endian {N, N words} byte image into instruction memory,
// then releases the core. The macro BIP2_BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module bip2_boot_loader #(
    parameter int OPERAND_ADDRESS_WIDTH  = 11,
    parameter int INSTRUCTION_DATA_WIDTH = 16
) (
    input  logic                      clock_in,
    input  logic                      reset_in,
    bip2_boot_loader_if.master        bus,
    input  logic                      reload_in,
    output logic                      core_reset_out,
    output logic                      busy_out,
    output logic                      error_out
);

    generate
        if (INSTRUCTION_DATA_WIDTH != 16) begin : g_bad_width
            $error("bip2_boot_loader: INSTRUCTION_DATA_WIDTH must be 16");
        end
    endgenerate

    localparam logic [2:0] HDR_LO  = 3'd0;
    localparam logic [2:0] HDR_HI  = 3'd1;
    localparam logic [2:0] WORD_LO = 3'd2;
    localparam logic [2:0] WORD_HI = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd5;
    localparam logic [2:0] RUN     = 3'd6;
    localparam logic [2:0] ERROR   = 3'd7;
`ifdef BIP2_BOOT_CHECKSUM_EN
    localparam logic [2:0] CHK        = 3'd4;
    localparam logic [2:0] AFTER_DATA = CHK;
`else
    localparam logic [2:0] AFTER_DATA = DRAIN;
`endif

    localparam logic [31:0] MAX_WORDS = 32'd1 << OPERAND_ADDRESS_WIDTH;

    logic [2:0]                        state_r, state_s;
    logic [15:0]                       n_r, n_s, n_full_s;
    logic [15:0]                       cnt_r, cnt_s;
    logic [7:0]                        low_r, low_s;
    logic [OPERAND_ADDRESS_WIDTH-1:0]  addr_r, addr_s;
    logic [INSTRUCTION_DATA_WIDTH-1:0] data_r, data_s;
    logic                              wr_r, wr_s;
    logic                              ready_r, ready_s;
    logic                              core_reset_r, core_reset_s;
    logic                              busy_r, busy_s;
    logic                              error_r, error_s;
    logic                              accept_s;
`ifdef BIP2_BOOT_CHECKSUM_EN
    logic [7:0]                        chk_r, chk_s;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction
`endif

    assign bus.load_ready_out   = ready_r;
    assign bus.imem_address_out = addr_r;
    assign bus.imem_data_out    = data_r;
    assign bus.imem_wr_out      = wr_r;
    assign core_reset_out       = core_reset_r;
    assign busy_out             = busy_r;
    assign error_out            = error_r;

    // Next-state, capture and registered-output decode.
    always_comb begin
        accept_s = bus.load_valid_in & ready_r;
        n_full_s = {bus.load_data_in, n_r[7:0]};
        state_s  = state_r;
        n_s      = n_r;
        cnt_s    = cnt_r;
        low_s    = low_r;
        addr_s   = addr_r;
        data_s   = data_r;
        wr_s     = 1'b0;
`ifdef BIP2_BOOT_CHECKSUM_EN
        if (accept_s && (state_r != CHK)) begin
            chk_s = chk_update(chk_r, bus.load_data_in);
        end else begin
            chk_s = chk_r;
        end
`endif
        case (state_r)
            HDR_LO: begin
                if (accept_s) begin
                    n_s     = {n_r[15:8], bus.load_data_in};
                    state_s = HDR_HI;
                end else begin
                    state_s = state_r;
                end
            end
            HDR_HI: begin
                if (accept_s) begin
                    n_s = n_full_s;
                    if (32'(n_full_s) > MAX_WORDS) begin
                        state_s = ERROR;
                    end else if (n_full_s == 16'd0) begin
                        state_s = AFTER_DATA;
                    end else begin
                        state_s = WORD_LO;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            WORD_LO: begin
                if (accept_s) begin
                    low_s   = bus.load_data_in;
                    state_s = WORD_HI;
                end else begin
                    state_s = state_r;
                end
            end
            WORD_HI: begin
                if (accept_s) begin
                    wr_s   = 1'b1;
                    data_s = {bus.load_data_in, low_r};
                    addr_s = cnt_r[OPERAND_ADDRESS_WIDTH-1:0];
                    cnt_s  = cnt_r + 16'd1;
                    if (cnt_r == (n_r - 16'd1)) begin
                        state_s = AFTER_DATA;
                    end else begin
                        state_s = WORD_LO;
                    end
                end else begin
                    state_s = state_r;
                end
            end
`ifdef BIP2_BOOT_CHECKSUM_EN
            CHK: begin
                if (accept_s) begin
                    if (bus.load_data_in == chk_r) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ERROR;
                    end
                end else begin
                    state_s = state_r;
                end
            end
`endif
            DRAIN: begin
                state_s = RUN;
            end
            RUN, ERROR: begin
                if (reload_in) begin
                    state_s = HDR_LO;
                    n_s     = 16'd0;
                    cnt_s   = 16'd0;
`ifdef BIP2_BOOT_CHECKSUM_EN
                    chk_s   = 8'd0;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ERROR;
            end
        endcase

        ready_s = (state_s == HDR_LO) || (state_s == HDR_HI) ||
                  (state_s == WORD_LO) || (state_s == WORD_HI)
`ifdef BIP2_BOOT_CHECKSUM_EN
                  || (state_s == CHK)
`endif
                  ;
        // The core is released only after a full cycle spent in RUN, but is re-held immediately on leaving it.
        core_reset_s = !((state_r == RUN) && (state_s == RUN));
        busy_s       = (state_s != RUN) && (state_s != ERROR);
        error_s      = (state_s == ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_r      <= HDR_LO;
            n_r          <= 16'd0;
            cnt_r        <= 16'd0;
            low_r        <= 8'd0;
            addr_r       <= '0;
            data_r       <= '0;
            wr_r         <= 1'b0;
            ready_r      <= 1'b1;
            core_reset_r <= 1'b1;
            busy_r       <= 1'b1;
            error_r      <= 1'b0;
`ifdef BIP2_BOOT_CHECKSUM_EN
            chk_r        <= 8'd0;
`endif
        end else begin
            state_r      <= state_s;
            n_r          <= n_s;
            cnt_r        <= cnt_s;
            low_r        <= low_s;
            addr_r       <= addr_s;
            data_r       <= data_s;
            wr_r         <= wr_s;
            ready_r      <= ready_s;
            core_reset_r <= core_reset_s;
            busy_r       <= busy_s;
            error_r      <= error_s;
`ifdef BIP2_BOOT_CHECKSUM_EN
            chk_r        <= chk_s;
`endif
        end
    end

endmodule

// File: tb/tb_bip2_boot_loader.sv
// Self-checking bench for bip2_boot_loader: directed image table, hand sequences and random images
// checked against an image-level reference model. Honours BIP2_BOOT_CHECKSUM_EN like the design.
module tb_bip2_boot_loader;
    localparam int AW = 11;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;
    typedef struct {
        int          len;
        logic [63:0] b;
        int          mode;
        int          nwr;
        logic [15:0] a0;
        logic [15:0] d0;
        logic [15:0] a1;
        logic [15:0] d1;
        bit          err;
    } vec_t;

    logic clk = 1'b0;
    logic rst, reload, core_reset, busy, error;

    bip2_boot_loader_if #(.OPERAND_ADDRESS_WIDTH(AW), .INSTRUCTION_DATA_WIDTH(16)) bus ();

    bip2_boot_loader #(.OPERAND_ADDRESS_WIDTH(AW), .INSTRUCTION_DATA_WIDTH(16)) dut (
        .clock_in       (clk),
        .reset_in       (rst),
        .bus            (bus),
        .reload_in      (reload),
        .core_reset_out (core_reset),
        .busy_out       (busy),
        .error_out      (error)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass = 0;
    int  strobe_viol = 0;
    int  timeouts = 0;
    bit  prev_wr = 1'b0;
    wr_t got_q[$];
    wr_t exp_q[$];
    bit  exp_err;
    int  exp_len;
    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance one clock, sample just after the edge and log any write strobe.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.imem_wr_out === 1'b1) begin
            if (prev_wr) strobe_viol++;
            got_q.push_back('{bus.imem_address_out, bus.imem_data_out});
        end
        prev_wr = (bus.imem_wr_out === 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reload = 1'b0;
        bus.load_valid_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
        strobe_viol = 0;
        prev_wr = 1'b0;
    endtask

    task automatic reload_pulse();
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_ctl{core_reset,busy,ready,error}", {core_reset, busy, bus.load_ready_out, error}, 4'b1110);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   done;
        done = 1'b0;
        bus.load_valid_in = 1'b1;
        bus.load_data_in  = b;
        for (int k = 0; k < 20 && !done; k++) begin
            rdy = bus.load_ready_out;
            step();
            if (rdy) done = 1'b1;
        end
        if (!done) timeouts++;
        bus.load_valid_in = 1'b0;
    endtask

    // Reference model: expected writes, final status and number of bytes the loader consumes.
    function automatic void model(input bq_t b);
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = {b[1], b[0]};
        if (n > (1 << AW)) begin
            exp_err = 1'b1;
            exp_len = 2;
            return;
        end
        for (int i = 0; i < n; i++) exp_q.push_back('{AW'(i), {b[3 + 2*i], b[2 + 2*i]}});
        exp_len = 2 + 2*n;
        exp_err = 1'b0;
`ifdef BIP2_BOOT_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < exp_len; i++) x = x ^ b[i];
        exp_err = (b[exp_len] != x);
        exp_len = exp_len + 1;
`else
        x = 8'h00;
        if (x != 8'h00) exp_err = 1'b1;
`endif
    endfunction

    // Stream an image (mode 0: valid held, 1: valid toggling, 2: random gaps) and check the outcome.
    task automatic run_image(input bq_t b, input int mode);
        int   idx, budget;
        logic rdy, v, phase;
        idx = 0;
        budget = 0;
        phase = 1'b1;
        got_q.delete();
        strobe_viol = 0;
        while (idx < exp_len && budget < 20000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = phase;
                default: v = ($urandom_range(0, 9) >= 3);
            endcase
            phase = ~phase;
            bus.load_valid_in = v;
            bus.load_data_in  = b[idx];
            rdy = bus.load_ready_out;
            step();
            if (v && rdy) idx++;
            budget++;
        end
        bus.load_valid_in = 1'b0;
        check("bytes_accepted", idx, exp_len);
        if (exp_err) begin
            check("error_ctl{error,ready,core_reset,busy}", {error, bus.load_ready_out, core_reset, busy}, 4'b1010);
        end else begin
            check("drain_ctl{core_reset,busy}", {core_reset, busy}, 2'b11);
            step();
            check("run1_ctl{core_reset,busy,ready,error}", {core_reset, busy, bus.load_ready_out, error}, 4'b1000);
            step();
            check("release_core_reset", core_reset, 1'b0);
        end
        check("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("wr_addr", got_q[i].addr, exp_q[i].addr);
            check("wr_data", got_q[i].data, exp_q[i].data);
        end
        check("wr_strobe_one_cycle", strobe_viol, 0);
        if (exp_q.size() > 0) check("data_hold", bus.imem_data_out, exp_q[exp_q.size()-1].data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t b;
        int  n;
        logic [7:0] x;
        bus.load_valid_in = 1'b0;
        bus.load_data_in  = 8'h00;
        reload = 1'b0;
        rst = 1'b1;
        do_reset();
        check("reset_ctl{core_reset,busy,wr,error,ready}", {core_reset, busy, bus.imem_wr_out, error, bus.load_ready_out}, 5'b11001);
        check("reset_addr", bus.imem_address_out, 0);
        check("reset_data", bus.imem_data_out, 0);

`ifdef BIP2_BOOT_CHECKSUM_EN
        tbl[0] = '{5, 64'h27_1234_0001, 0, 1, 16'd0, 16'h1234, 16'd0, 16'h0000, 1'b0};
        tbl[1] = '{5, 64'h28_1234_0001, 0, 1, 16'd0, 16'h1234, 16'd0, 16'h0000, 1'b1};
        tbl[2] = '{2, 64'h0801,         0, 0, 16'd0, 16'h0000, 16'd0, 16'h0000, 1'b1};
        tbl[3] = '{5, 64'h50_BEEF_0001, 1, 1, 16'd0, 16'hBEEF, 16'd0, 16'h0000, 1'b0};
`else
        tbl[0] = '{6, 64'hABCD_1234_0002, 0, 2, 16'd0, 16'h1234, 16'd1, 16'hABCD, 1'b0};
        tbl[1] = '{2, 64'h0000,           0, 0, 16'd0, 16'h0000, 16'd0, 16'h0000, 1'b0};
        tbl[2] = '{2, 64'h0801,           0, 0, 16'd0, 16'h0000, 16'd0, 16'h0000, 1'b1};
        tbl[3] = '{4, 64'hBEEF_0001,      1, 1, 16'd0, 16'hBEEF, 16'd0, 16'h0000, 1'b0};
`endif
        for (int t = 0; t < 4; t++) begin
            do_reset();
            b = {};
            for (int i = 0; i < tbl[t].len; i++) b.push_back(tbl[t].b[8*i +: 8]);
            exp_q.delete();
            if (tbl[t].nwr > 0) exp_q.push_back('{AW'(tbl[t].a0), tbl[t].d0});
            if (tbl[t].nwr > 1) exp_q.push_back('{AW'(tbl[t].a1), tbl[t].d1});
            exp_err = tbl[t].err;
            exp_len = tbl[t].len;
            run_image(b, tbl[t].mode);
            if (tbl[t].err) reload_pulse();
        end

        // From RUN: reload re-holds the core on the next edge, then a fresh image loads.
        reload_pulse();
        b = {8'h01, 8'h00, 8'h11, 8'h22};
`ifdef BIP2_BOOT_CHECKSUM_EN
        b.push_back(8'h32);
`endif
        model(b);
        run_image(b, 0);

        // Reload held while loading is ignored; then reset lands mid-WORD_HI.
        reload_pulse();
        got_q.delete();
        send_byte(8'h02);
        send_byte(8'h00);
        reload = 1'b1;
        send_byte(8'h33);
        send_byte(8'h44);
        reload = 1'b0;
        check("ignored_reload_wr_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("ignored_reload_wr_addr", got_q[0].addr, 0);
            check("ignored_reload_wr_data", got_q[0].data, 16'h4433);
        end
        send_byte(8'h55);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midload_reset_ctl{core_reset,busy,wr,error,ready}", {core_reset, busy, bus.imem_wr_out, error, bus.load_ready_out}, 5'b11001);
        check("midload_reset_addr", bus.imem_address_out, 0);
        check("midload_reset_data", bus.imem_data_out, 0);
        check("send_timeouts", timeouts, 0);

        // Random images, including the 2**AW and 2**AW+1 size boundaries.
        for (int it = 0; it < 24; it++) begin
            if (it > 0) reload_pulse();
            if (it == 0) n = 1 << AW;
            else if (it == 1) n = (1 << AW) + 1;
            else if ($urandom_range(0, 7) == 0) n = $urandom_range((1 << AW) + 1, 65535);
            else n = $urandom_range(0, 5);
            b = {};
            b.push_back(8'(n));
            b.push_back(8'(n >> 8));
            for (int i = 0; i < ((n > (1 << AW)) ? 2 : 2*n); i++) b.push_back(8'($urandom));
            x = 8'h00;
            foreach (b[i]) x = x ^ b[i];
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            b.push_back(x);
            model(b);
            run_image(b, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
